crypto1_keystream: RTL

- Forward Crypto1 keystream generator: loads a 48-bit key into the LFSR, clocks it, and emits the filtered keystream serially with a valid/ready handshake.
- Inverse of the attack datapath. It produces the BITSTREAM vectors consumed by the attack cores.
- It also serves as the final verifier: it re-runs a recovered candidate key and compares the result against the known 48-bit output stream.

---
 rtl/crypto1_pkg.sv | 50 +++++
 rtl/crypto1_lfsr.sv | 37 +++
 rtl/crypto1_keystream.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/crypto1_pkg.sv
// ---------------------------------------------------------------------------
// crypto1_pkg
//   Shared Crypto1 constants and combinational helpers. This package is used
//   by the forward keystream generator and by the attack cores.
//
//   STATE_W   : LFSR width (48)
//   TAP_MASK  : feedback taps 0,5,9,10,12,14,15,17,19,24,25,27,29,35,39,41,42,43
//   FA_TBL / FB_TBL / FC_TBL : filter lookup tables
//   ks_state_t: keystream FSM encoding
//   crypto1_filter(x) : filter output f(x)
//   crypto1_step(x)   : one LFSR step, {fb, x[47:1]}
// ---------------------------------------------------------------------------
package crypto1_pkg;

    localparam int          STATE_W  = 48;
    localparam logic [47:0] TAP_MASK = 48'h0E882B0AD621;

    localparam logic [15:0] FA_TBL = 16'h26C7;
    localparam logic [15:0] FB_TBL = 16'h0DD3;
    localparam logic [31:0] FC_TBL = 32'h4457C3B3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } ks_state_t;

    // Four odd state bits starting at 'base', lowest index as the LSB.
    function automatic logic [3:0] crypto1_nibble(input logic [47:0] x, input int base);
        return {x[base+6], x[base+4], x[base+2], x[base]};
    endfunction

    // Two-layer filter: five nibble lookups build a 5-bit index into FC_TBL.
    function automatic logic crypto1_filter(input logic [47:0] x);
        logic [4:0] idx;
        idx[0] = FA_TBL[crypto1_nibble(x, 9)];
        idx[1] = FB_TBL[crypto1_nibble(x, 17)];
        idx[2] = FB_TBL[crypto1_nibble(x, 25)];
        idx[3] = FA_TBL[crypto1_nibble(x, 33)];
        idx[4] = FB_TBL[crypto1_nibble(x, 41)];
        return FC_TBL[idx];
    endfunction

    // Feedback enters at the top while the state shifts toward bit 0.
    function automatic logic [47:0] crypto1_step(input logic [47:0] x);
        return {^(x & TAP_MASK), x[47:1]};
    endfunction

endpackage

// File: rtl/crypto1_lfsr.sv
// ---------------------------------------------------------------------------
// crypto1_lfsr
//   48-bit Crypto1 state register. Load has priority over step.
//
//   clk   in   clock
//   reset in   asynchronous active-high reset (state -> 0)
//   load  in   capture key into the state (x[i] <= key[i])
//   key   in   48-bit key
//   step  in   advance the LFSR by one position
//   state out  current state x[47:0]
// ---------------------------------------------------------------------------
module crypto1_lfsr
    import crypto1_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [47:0] key,
    input  logic        step,
    output logic [47:0] state
);

    logic [STATE_W-1:0] x_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q <= '0;
        end else if (load) begin
            x_q <= key;
        end else if (step) begin
            x_q <= crypto1_step(x_q);
        end
    end

    assign state = x_q;

endmodule

// File: rtl/crypto1_keystream.sv
// ---------------------------------------------------------------------------
// crypto1_keystream
//   Forward Crypto1 keystream generator. Loads a key, then emits NBITS
//   filtered bits serially, one per accepted transfer.
//
//   Handshake: a bit transfers on any rising edge where ks_valid && ks_ready.
//   Once ks_valid rises it stays high, and ks_data holds, until that transfer.
//
//   clk          in   clock
//   reset        in   asynchronous active-high reset (aborts a run, no done)
//   key[47:0]    in   key, sampled when start is seen in IDLE
//   start        in   begins a run from IDLE, ignored elsewhere
//   ks_data      out  current keystream bit (registered)
//   ks_valid     out  ks_data is valid
//   ks_ready     in   sink accepts the bit
//   busy         out  high in LOAD and RUN
//   done         out  one-cycle pulse after the last transfer
//   state_dbg    out  FSM state (ks_state_t encoding)
//
//   Optional, macro CRYPTO1_KS_CHECK_EN:
//   expected[NBITS-1:0] in   reference stream, first bit at the MSB
//   match               out  1 when every bit agreed (valid with done)
//   mismatch_idx        out  count of the first differing bit, 0 on match
// ---------------------------------------------------------------------------
module crypto1_keystream
    import crypto1_pkg::*;
#(
    parameter int NBITS = 64,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [47:0]      key,
    input  logic             start,
    input  logic             ks_ready,
`ifdef CRYPTO1_KS_CHECK_EN
    input  logic [NBITS-1:0] expected,
    output logic             match,
    output logic [CNT_W-1:0] mismatch_idx,
`endif
    output logic             ks_data,
    output logic             ks_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    ks_state_t          state_q, state_d;
    logic [CNT_W-1:0]   count_q;
    logic               ks_data_q;
    logic [STATE_W-1:0] x;
    logic               lfsr_load;
    logic               lfsr_step;
    logic               xfer;
    logic               last;

    crypto1_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (lfsr_load),
        .key   (key),
        .step  (lfsr_step),
        .state (x)
    );

    assign xfer = (state_q == RUN) && ks_ready;
    assign last = (count_q == CNT_W'(NBITS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        ks_valid  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    lfsr_load = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                busy    = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                busy     = 1'b1;
                ks_valid = 1'b1;
                if (ks_ready) begin
                    lfsr_step = 1'b1;
                    if (last) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ks_data is registered: LOAD precomputes f(key); each transfer
    // precomputes the filter of the state the LFSR is about to hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            ks_data_q <= 1'b0;
        end else if (state_q == LOAD) begin
            count_q   <= '0;
            ks_data_q <= crypto1_filter(x);
        end else if (xfer) begin
            count_q   <= count_q + CNT_W'(1);
            ks_data_q <= crypto1_filter(crypto1_step(x));
        end
    end

    assign ks_data   = ks_data_q;
    assign state_dbg = state_q;

`ifdef CRYPTO1_KS_CHECK_EN
    // The reference is captured at start and shifted left so the bit under
    // comparison is always the MSB.
    logic [NBITS-1:0] exp_sr_q;
    logic             err_q;
    logic             match_q;
    logic [CNT_W-1:0] idx_q;
    logic             bit_bad;

    assign bit_bad = (ks_data_q != exp_sr_q[NBITS-1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_sr_q <= '0;
            err_q    <= 1'b0;
            match_q  <= 1'b0;
            idx_q    <= '0;
        end else if (state_q == IDLE && start) begin
            exp_sr_q <= expected;
            err_q    <= 1'b0;
            match_q  <= 1'b0;
            idx_q    <= '0;
        end else if (xfer) begin
            exp_sr_q <= exp_sr_q << 1;
            if (bit_bad && !err_q) begin
                err_q <= 1'b1;
                idx_q <= count_q;
            end
            if (last) begin
                match_q <= !(err_q || bit_bad);
            end
        end
    end

    assign match        = match_q;
    assign mismatch_idx = idx_q;
`endif

endmodule
